// File: rtl/dcache_responder.sv
// Direct-mapped, write-back, write-allocate data cache with 4-word lines.
// Misses are serviced over a line-wide request/ready handshake to memory.
//
// state     | meaning
// IDLE      | serve hits; on a miss launch writeback or fill
// WRITEBACK | dirty victim on mem_wdata, waiting for mem_ready
// ALLOCATE  | fill request outstanding, waiting for mem_ready
module dcache_responder #(
  parameter int NUM_LINES = 8,
  parameter int IDX_W     = 3,
  parameter int TAG_W     = 28 - IDX_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          proc_read,
  input  logic          proc_write,
  input  logic [29:0]   proc_addr,
  input  logic [31:0]   proc_wdata,
  output logic          proc_stall,
  output logic [31:0]   proc_rdata,
  output logic          mem_read,
  output logic          mem_write,
  output logic [27:0]   mem_addr,
  output logic [127:0]  mem_wdata,
  input  logic [127:0]  mem_rdata,
  input  logic          mem_ready
);

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

  state_t               state_q, state_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [NUM_LINES-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [TAG_W-1:0]     tag_d  [NUM_LINES];
  logic [127:0]         data_q [NUM_LINES];
  logic [127:0]         data_d [NUM_LINES];
  logic                 mem_read_q, mem_read_d;
  logic                 mem_write_q, mem_write_d;
  logic [27:0]          mem_addr_q, mem_addr_d;
  logic [127:0]         mem_wdata_q, mem_wdata_d;

  logic               req;
  logic               hit;
  logic [IDX_W-1:0]   idx;
  logic [1:0]         off;
  logic [TAG_W-1:0]   addr_tag;
  logic [127:0]       line;
  logic [31:0]        word;

  assign req      = proc_read | proc_write;
  assign idx      = proc_addr[IDX_W+1:2];
  assign off      = proc_addr[1:0];
  assign addr_tag = proc_addr[29:IDX_W+2];
  assign line     = data_q[idx];
  assign word     = line[{off, 5'b0} +: 32];
  assign hit      = req & valid_q[idx] & (tag_q[idx] == addr_tag);

  assign proc_stall = (state_q == IDLE) ? (req & ~hit) : 1'b1;
  assign proc_rdata = (proc_read & hit) ? word : 32'h0;

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    tag_d       = tag_q;
    data_d      = data_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            // A write wins over a simultaneous read.
            if (proc_write) begin
              data_d[idx][{off, 5'b0} +: 32] = proc_wdata;
              dirty_d[idx]                   = 1'b1;
            end
          end else if (valid_q[idx] && dirty_q[idx]) begin
            state_d     = WRITEBACK;
            mem_write_d = 1'b1;
            mem_addr_d  = {tag_q[idx], idx};
            mem_wdata_d = data_q[idx];
          end else begin
            state_d    = ALLOCATE;
            mem_read_d = 1'b1;
            mem_addr_d = proc_addr[29:2];
          end
        end
      end
      WRITEBACK: begin
        if (mem_ready) begin
          dirty_d[idx] = 1'b0;
          mem_write_d  = 1'b0;
          mem_read_d   = 1'b1;
          mem_addr_d   = proc_addr[29:2];
          state_d      = ALLOCATE;
        end
      end
      ALLOCATE: begin
        // Pending writes merge on the re-evaluated hit in the next IDLE cycle.
        if (mem_ready) begin
          data_d[idx]  = mem_rdata;
          tag_d[idx]   = addr_tag;
          valid_d[idx] = 1'b1;
          dirty_d[idx] = 1'b0;
          mem_read_d   = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Tag and data arrays carry no reset; a reset edge must not commit a partial fill.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tag_q  <= tag_d;
      data_q <= data_d;
    end
  end

endmodule
